// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bus bundle around dmem_arbiter. Carries the core load/store
//                port, the debug/loader port and the data-memory port.
//                The slave modport is the arbiter; the master modport is its
//                surroundings (core, debug agent and data memory together).
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  // Core load/store port
  logic          c_req;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          core_stall;

  // Debug/loader port
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_lock;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  // Data-memory port
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, core_stall,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, core_stall,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter sharing a single-port synchronous-read
//                data memory between the core load/store port and a
//                debug/loader port. One access per cycle, combinational
//                grant, read data routed back one cycle after the grant.
//                Optional macro DMEM_ARB_LOCK_EN: d_lock with d_req lets the
//                debug port win every contention until either drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dmem_arbiter_if.slave  bus
);

  // Port identifiers used by the last-grant and read-owner registers
  localparam logic c_port_core = 1'b0;
  localparam logic c_port_dbg  = 1'b1;

  logic          r_last;      // port granted most recently
  logic          r_rd_valid;  // a read was issued last cycle
  logic          r_rd_port;   // port that issued that read
  logic          w_c_gnt;
  logic          w_d_gnt;
  logic          w_lock_win;
  logic          w_any_gnt;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_c_rvalid;
  logic          w_d_rvalid;

  // Debug lock override; constant zero when the feature is compiled out
  always_comb begin
    w_lock_win = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    w_lock_win = bus.d_lock & bus.d_req;
`endif
  end

  // Grant decision: lone requester wins, contention goes to the port not
  // granted last time; nothing is granted while in reset
  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!rst) begin
      if (w_lock_win) begin
        w_d_gnt = 1'b1;
      end else if (bus.c_req && bus.d_req) begin
        if (r_last == c_port_dbg) begin
          w_c_gnt = 1'b1;
        end else begin
          w_d_gnt = 1'b1;
        end
      end else begin
        w_c_gnt = bus.c_req;
        w_d_gnt = bus.d_req;
      end
    end
  end

  assign w_any_gnt = w_c_gnt | w_d_gnt;

  // Memory-side mux: granted port's command, all zero when idle
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_c_gnt) begin
      w_sel_we    = bus.c_we;
      w_sel_addr  = bus.c_addr[AW+1:2];
      w_sel_wdata = bus.c_wdata;
    end else if (w_d_gnt) begin
      w_sel_we    = bus.d_we;
      w_sel_addr  = bus.d_addr[AW+1:2];
      w_sel_wdata = bus.d_wdata;
    end
  end

  // Round-robin pointer and read-owner tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= c_port_dbg;
      r_rd_valid <= 1'b0;
      r_rd_port  <= c_port_core;
    end else begin
      if (w_any_gnt) begin
        r_last <= w_d_gnt ? c_port_dbg : c_port_core;
      end
      r_rd_valid <= w_any_gnt & ~w_sel_we;
      r_rd_port  <= w_d_gnt ? c_port_dbg : c_port_core;
    end
  end

  // A reset arriving in the cycle after a read grant kills that response
  assign w_c_rvalid = r_rd_valid & ~rst & (r_rd_port == c_port_core);
  assign w_d_rvalid = r_rd_valid & ~rst & (r_rd_port == c_port_dbg);

  assign bus.c_gnt      = w_c_gnt;
  assign bus.d_gnt      = w_d_gnt;
  assign bus.core_stall = ~rst & bus.c_req & ~w_c_gnt;
  assign bus.c_rvalid   = w_c_rvalid;
  assign bus.d_rvalid   = w_d_rvalid;
  assign bus.c_rdata    = w_c_rvalid ? bus.m_rdata : {DW{1'b0}};
  assign bus.d_rdata    = w_d_rvalid ? bus.m_rdata : {DW{1'b0}};

  assign bus.m_en    = w_any_gnt;
  assign bus.m_we    = w_sel_we;
  assign bus.m_addr  = w_sel_addr;
  assign bus.m_wdata = w_sel_wdata;

  // Byte-offset and out-of-range address bits are intentionally dropped
  logic w_unused;
  assign w_unused = &{1'b0, bus.c_addr[31:AW+2], bus.c_addr[1:0],
                      bus.d_addr[31:AW+2], bus.d_addr[1:0], bus.d_lock};

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: directed scenarios
//                with literal expectations followed by randomized traffic,
//                all compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  dmem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Data memory device (synchronous read, write on strobe)
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata     <= mem[bus.m_addr];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit          mdl_last_dbg = 1'b1;   // who won the most recent grant
  bit          pend_v = 1'b0, pend_dbg = 1'b0;
  logic [31:0] pend_data = '0;
  bit          nxt_last_dbg = 1'b1, nxt_pend_v = 1'b0, nxt_pend_dbg = 1'b0;
  logic [31:0] nxt_pend_data = '0;
  bit          m_c_gnt = 1'b0, m_d_gnt = 1'b0;

  always @(posedge clk) begin
    mdl_last_dbg <= nxt_last_dbg;
    pend_v       <= nxt_pend_v;
    pend_dbg     <= nxt_pend_dbg;
    pend_data    <= nxt_pend_data;
  end

  // Compare process: every cycle, model vs DUT on the falling edge
  initial begin : compare
    bit gc, gd, we, ev;
    int idx;
    logic [31:0] wd;
    forever begin
      @(negedge clk);
      gc = 1'b0; gd = 1'b0; we = 1'b0; idx = 0; wd = '0;
      if (!rst) begin
        if (bus.c_req && bus.d_req) begin
          if (LOCK_ON && bus.d_lock) gd = 1'b1;
          else if (mdl_last_dbg)     gc = 1'b1;
          else                       gd = 1'b1;
        end else begin
          gc = bus.c_req;
          gd = bus.d_req;
        end
      end
      m_c_gnt = gc;
      m_d_gnt = gd;
      if (gc) begin
        idx = (bus.c_addr % 32'(4 * DEPTH)) / 4; we = bus.c_we; wd = bus.c_wdata;
      end else if (gd) begin
        idx = (bus.d_addr % 32'(4 * DEPTH)) / 4; we = bus.d_we; wd = bus.d_wdata;
      end
      ev = pend_v && !rst;
      chk("c_gnt",      32'(bus.c_gnt),      32'(gc));
      chk("d_gnt",      32'(bus.d_gnt),      32'(gd));
      chk("core_stall", 32'(bus.core_stall), 32'(!rst && bus.c_req && !gc));
      chk("m_en",       32'(bus.m_en),       32'(gc || gd));
      chk("m_we",       32'(bus.m_we),       32'(we));
      chk("m_addr",     32'(bus.m_addr),     32'(idx));
      chk("m_wdata",    32'(bus.m_wdata),    wd);
      chk("c_rvalid",   32'(bus.c_rvalid),   32'(ev && !pend_dbg));
      chk("d_rvalid",   32'(bus.d_rvalid),   32'(ev && pend_dbg));
      chk("c_rdata",    32'(bus.c_rdata),    (ev && !pend_dbg) ? pend_data : 32'h0);
      chk("d_rdata",    32'(bus.d_rdata),    (ev && pend_dbg) ? pend_data : 32'h0);
      if (rst) begin
        nxt_last_dbg = 1'b1;
        nxt_pend_v   = 1'b0;
      end else begin
        if (gc || gd) nxt_last_dbg = gd;
        else          nxt_last_dbg = mdl_last_dbg;
        nxt_pend_v    = (gc || gd) && !we;
        nxt_pend_dbg  = gd;
        nxt_pend_data = ref_mem[idx];
        if ((gc || gd) && we) ref_mem[idx] = wd;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.d_lock = 1'b0;
  endtask

  task automatic core(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd;
  endtask

  task automatic dbg(input bit we, input logic [31:0] a, input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[AW+1:2] = AW'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin : main
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA5A5_0000 + 32'(i);
      ref_mem[i] = 32'hA5A5_0000 + 32'(i);
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    bus.m_rdata = '0;
    idle();
    rst = 1'b1;
    core(1'b0, 32'h0, 32'h0);
    dbg(1'b0, 32'h4, 32'h0);

    // Reset forces grants, strobe and stall low even with requests present
    @(negedge clk);
    chk("rst_c_gnt", 32'(bus.c_gnt), 32'h0);
    chk("rst_stall", 32'(bus.core_stall), 32'h0);
    chk("rst_m_en",  32'(bus.m_en), 32'h0);
    tick();
    idle();
    tick();
    rst = 1'b0;
    tick();

    // Core read alone of word 4
    core(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("lit_c_gnt", 32'(bus.c_gnt), 32'h1);
    chk("lit_m_addr", 32'(bus.m_addr), 32'h4);
    tick();
    idle();
    @(negedge clk);
    chk("lit_c_rvalid", 32'(bus.c_rvalid), 32'h1);
    chk("lit_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
    chk("lit_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    tick();

    // Contention from reset: C, D, C, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core(1'b0, 32'h40, 32'h0);
    dbg(1'b0, 32'h44, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_rr_c_gnt", 32'(bus.c_gnt), 32'(k % 2 == 0));
      chk("lit_rr_d_gnt", 32'(bus.d_gnt), 32'(k % 2 == 1));
      chk("lit_rr_stall", 32'(bus.core_stall), 32'(k % 2 == 1));
      tick();
    end
    idle();
    tick();

    // Debug write then core read of the same word
    dbg(1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("lit_dw_gnt", 32'(bus.d_gnt), 32'h1);
    tick();
    idle();
    core(1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("lit_cr_gnt", 32'(bus.c_gnt), 32'h1);
    tick();
    idle();
    @(negedge clk);
    chk("lit_cr_rvalid", 32'(bus.c_rvalid), 32'h1);
    chk("lit_cr_rdata", bus.c_rdata, 32'h1234_5678);
    tick();

    // Lock: debug owns the memory while d_lock is held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core(1'b0, 32'h48, 32'h0);
    dbg(1'b0, 32'h4C, 32'h0);
    bus.d_lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_lock_d_gnt", 32'(bus.d_gnt), LOCK_ON ? 32'h1 : 32'(k % 2 == 1));
      chk("lit_lock_stall", 32'(bus.core_stall), LOCK_ON ? 32'h1 : 32'(k % 2 == 1));
      tick();
    end
    bus.d_req = 1'b0;
    bus.d_lock = 1'b0;
    tick();
    idle();
    tick();

    // Reset in the cycle after a core read grant suppresses rvalid
    core(1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("lit_mr_gnt", 32'(bus.c_gnt), 32'h1);
    tick();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("lit_mr_rvalid", 32'(bus.c_rvalid), 32'h0);
    tick();
    rst = 1'b0;
    core(1'b0, 32'h50, 32'h0);
    dbg(1'b0, 32'h54, 32'h0);
    @(negedge clk);
    chk("lit_mr_first", 32'(bus.c_gnt), 32'h1);
    tick();
    bus.c_req = 1'b0;
    tick();
    idle();
    tick();

    // Core write lands while debug read data returns
    dbg(1'b0, 32'h24, 32'h0);
    @(negedge clk);
    chk("lit_pw_d_gnt", 32'(bus.d_gnt), 32'h1);
    tick();
    idle();
    core(1'b1, 32'h24, 32'hCAFE_F00D);
    @(negedge clk);
    chk("lit_pw_c_gnt", 32'(bus.c_gnt), 32'h1);
    chk("lit_pw_d_rvalid", 32'(bus.d_rvalid), 32'h1);
    chk("lit_pw_d_rdata", bus.d_rdata, 32'hA5A5_0009);
    tick();
    core(1'b0, 32'h24, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("lit_pw_c_rdata", bus.c_rdata, 32'hCAFE_F00D);
    tick();

    // Randomized traffic obeying the hold-until-granted rule
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(bus.c_req && !m_c_gnt)) begin
        bus.c_req = ($urandom_range(0, 2) != 0);
        bus.c_we = 1'($urandom_range(0, 1));
        bus.c_addr = rand_addr();
        bus.c_wdata = $urandom;
      end
      if (!(bus.d_req && !m_d_gnt)) begin
        bus.d_req = ($urandom_range(0, 2) != 0);
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = rand_addr();
        bus.d_wdata = $urandom;
      end
      bus.d_lock = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
